// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR MAC: FSM state encoding and
// the accumulator width rule.
package fir_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t MAC  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Accumulator width that holds TAPS full-scale products without overflow.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mul.sv
// Combinational unsigned DATA_W x COEF_W multiplier shared by all taps.
module fir_mul #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4
) (
  input  logic [DATA_W-1:0]        a,
  input  logic [COEF_W-1:0]        b,
  output logic [DATA_W+COEF_W-1:0] p
);

  localparam int PW = DATA_W + COEF_W;

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one product per cycle through a single shared
// multiplier, IDLE -> MAC -> DONE handshake FSM.
// Optional build macro FIR_MAC_SAT_EN: saturate the result to OUT_W bits
// instead of wrapping.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     coef_ready,
  output logic                     busy
);

  localparam int AW = acc_width(DATA_W, COEF_W, TAPS);
  localparam int IW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [AW-1:0]                  acc;
  logic [TAPS-1:0][DATA_W-1:0]    x;
  logic [TAPS-1:0][COEF_W-1:0]    coef;
  logic [PW-1:0]                  prod;
  logic [OUT_W-1:0]               res;
  logic                           accept;
  logic                           coef_wr;
  logic                           last;

  assign in_ready   = (state == IDLE);
  assign coef_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  // Addresses beyond TAPS-1 (non power-of-two tap counts) are dropped.
  assign coef_wr    = coef_we && coef_ready && (int'(coef_addr) < TAPS);
  assign last       = (idx == IW'(TAPS - 1));

  fir_mul #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_mul (
    .a (x[idx]),
    .b (coef[idx]),
    .p (prod)
  );

`ifdef FIR_MAC_SAT_EN
  localparam int WW = (AW > OUT_W) ? AW : OUT_W;
  logic [WW-1:0] acc_ext;
  logic [WW-1:0] sat_max;

  // Clamp the final sum to the largest OUT_W value.
  always_comb begin
    acc_ext = WW'(acc);
    sat_max = WW'({OUT_W{1'b1}});
    res     = (acc_ext > sat_max) ? sat_max[OUT_W-1:0] : acc_ext[OUT_W-1:0];
  end
`else
  // Keep the low OUT_W bits of the final sum (modular wrap).
  always_comb begin
    res = OUT_W'(acc);
  end
`endif

  // Coefficient file: writable only while idle, so a write in the same
  // cycle as a sample accept is already visible to the MAC pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef <= '0;
    end else if (coef_wr) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Delay line: slot 0 holds the newest sample; shifts only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
    end else if (accept) begin
      x <= {x[TAPS-2:0], in_data};
    end
  end

  // Control FSM and accumulator. DONE spends its first cycle registering
  // the result, then holds out_valid until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + AW'(prod);
          if (last) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_data  <= res;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: scripted directed cases plus a
// randomized phase, all checked every cycle against a transaction-level
// model (sample history + coefficient array + output countdown).
module tb_fir_mac_seq;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int TAPS   = 4;
  localparam int OUT_W  = 6;
  localparam int IW     = $clog2(TAPS);
  localparam int LAT    = TAPS + 1;
  localparam int OMAX   = (1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              coef_we = 1'b0;
  logic [IW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              coef_ready;
  logic              busy;

  always #5 clk = ~clk;

  fir_mac_seq #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .busy       (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mc[TAPS];
  int mh[TAPS];
  bit m_busy = 1'b0;
  int m_cnt  = 0;
  int m_exp  = 0;

  function automatic int expect_of(input int d, input bit we, input int a, input int cd);
    int c[TAPS];
    int h[TAPS];
    int s;
    c = mc;
    if (we) c[a] = cd;
    h[0] = d;
    for (int k = 1; k < TAPS; k++) h[k] = mh[k-1];
    s = 0;
    for (int k = 0; k < TAPS; k++) s += c[k] * h[k];
`ifdef FIR_MAC_SAT_EN
    return (s > OMAX) ? OMAX : s;
`else
    return s % (OMAX + 1);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        mc[k] <= 0;
        mh[k] <= 0;
      end
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (coef_we) mc[int'(coef_addr)] <= int'(coef_data);
      if (in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) mh[k] <= mh[k-1];
        mh[0]  <= int'(in_data);
        m_exp  <= expect_of(int'(in_data), coef_we, int'(coef_addr), int'(coef_data));
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end else begin
      if (m_cnt >= LAT && out_ready) m_busy <= 1'b0;
      else if (m_cnt < LAT)          m_cnt  <= m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_v;
    exp_v = m_busy && (m_cnt >= LAT);
    chk("out_valid",  out_valid,  exp_v);
    chk("in_ready",   in_ready,   !m_busy);
    chk("coef_ready", coef_ready, !m_busy);
    chk("busy",       busy,       m_busy);
    if (exp_v) chk("out_data", out_data, m_exp);
  end

  // ---------------- stimulus ----------------
  task automatic wcoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = IW'(a);
    coef_data = COEF_W'(d);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Caller is at a negedge with the DUT idle and out_ready high.
  task automatic send(input int d, output int lat, output int val);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    val = int'(out_data);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int v;
    int pinned;
    logic [OUT_W-1:0] held;

    repeat (3) @(negedge clk);
    chk("rst_out_data",   out_data,   0);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_coef_ready", coef_ready, 1);
    chk("rst_busy",       busy,       0);
    rst = 1'b0;
    @(negedge clk);

    wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 3);

    send(3, lat, v);
    pinned = m_exp;
    chk("first_val", v, 3);
    chk("first_lat", lat, 5);
    chk("pin_model_first", pinned, 3);

    send(2, lat, v);
    chk("second_val", v, 8);
    chk("second_lat", lat, 5);

    // Stall in DONE with a coefficient write attempted during MAC.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd1;
    @(negedge clk);
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 4'd9;
    @(negedge clk);
    coef_we   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_lat", lat, 5);
    chk("stall_val", out_data, 14);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid",  out_valid, 1);
      chk("stall_data",   out_data,  held);
      chk("stall_inrdy",  in_ready,  0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", out_valid, 0);
    send(1, lat, v);
    chk("coef_we_busy_ignored", v, 18);

    // Full-scale: all coefficients and samples at maximum.
    for (int k = 0; k < TAPS; k++) wcoef(k, 15);
    for (int k = 0; k < 4; k++) send(15, lat, v);
`ifdef FIR_MAC_SAT_EN
    chk("full_scale", v, 63);
`else
    chk("full_scale", v, 4);
`endif

    // Reset during the second MAC cycle aborts the computation.
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    in_valid = 1'b1;
    in_data  = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_inrdy", in_ready,  1);
    repeat (LAT + 2) @(negedge clk);
    chk("abort_no_valid", out_valid, 0);
    wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 3);
    send(5, lat, v);
    chk("after_abort", v, 5);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = IW'($urandom);
      coef_data = COEF_W'($urandom);
      @(negedge clk);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 4, unsigned sample width.
REQ-002 SHALL have parameter COEF_W, default 4, unsigned coefficient width.
REQ-003 SHALL have parameter TAPS, default 4, tap count, range 2..16.
REQ-004 SHALL have parameter OUT_W, default 6, output width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports in_data (input, DATA_W, sample), in_valid (input, 1) and in_ready (output, 1).
REQ-008 SHALL have ports out_data (output, OUT_W, filter result), out_valid (output, 1) and out_ready (input, 1).
REQ-009 SHALL have ports coef_we (input, 1), coef_addr (input, clog2(TAPS), tap index), coef_data (input, COEF_W) and coef_ready (output, 1).
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 SHALL compute y = sum over k of coef[k]*x[n-k], unsigned; x[n] is the newest sample.
REQ-012 SHALL time-share one DATA_W x COEF_W multiplier, issuing exactly one product per cycle.
REQ-013 SHALL implement the FSM IDLE -> MAC -> DONE -> IDLE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, SHALL shift in_data into delay line slot 0, clear the accumulator, set tap index 0 and go to MAC.
REQ-015 MAC: SHALL add coef[idx]*x[idx] to the accumulator each cycle, idx 0..TAPS-1, then go to DONE after idx=TAPS-1.
REQ-016 DONE: out_valid=1 and out_data held stable; on out_ready, SHALL return to IDLE, with out_valid low on the next cycle.
REQ-017 Latency SHALL be TAPS+1 cycles from the accept edge to out_valid high, assuming out_ready is already high.
REQ-018 Accumulator width SHALL be DATA_W+COEF_W+clog2(TAPS) and SHALL never overflow.
REQ-019 in_ready SHALL be 0 in MAC and DONE; in_valid there SHALL be ignored and no sample dropped from the delay line.
REQ-020 coef_ready SHALL equal IDLE; coef_we with coef_ready writes coef[coef_addr] on that edge; coef_we while busy SHALL be ignored.
REQ-021 Simultaneous coef_we and sample accept in IDLE: the write SHALL take effect first, so the new coefficient is used for this sample.
REQ-022 out_ready held low in DONE SHALL stall indefinitely with no state change.

Reset
REQ-023 rst SHALL force state IDLE, in_ready=1, coef_ready=1, out_valid=0, busy=0, out_data=0, accumulator=0 and all delay-line slots=0.
REQ-024 Coefficients SHALL reset to 0.
REQ-025 rst asserted mid-MAC or in DONE SHALL abort the computation; no out_valid follows.

Configuration
REQ-026 With FIR_MAC_SAT_EN defined, out_data SHALL be min(acc, 2^OUT_W-1).
REQ-027 Without FIR_MAC_SAT_EN, out_data SHALL be acc[OUT_W-1:0] (wrap).

Structure
REQ-028 A shared package fir_pkg SHALL hold the FSM state typedef (IDLE/MAC/DONE) and the accumulator-width function.
REQ-029 The multiplier SHALL be a separate combinational sub-module fir_mul (DATA_W x COEF_W -> DATA_W+COEF_W), instantiated once.

Verification (defaults, coef={1,2,3,3})
REQ-030 Reset, then sample 3: out_data=3, out_valid exactly 5 cycles after accept.
REQ-031 Then sample 2: out_data=8 (1*2+2*3).
REQ-032 All coef=15 and four samples of 15, fourth result: 63 with FIR_MAC_SAT_EN; 4 (900 mod 64) without.
REQ-033 out_ready=0 for 10 cycles in DONE: out_valid and out_data stable, in_ready=0; and coef_we during MAC leaves the coefficient unchanged.
REQ-034 rst on the 2nd MAC cycle: next cycle out_valid=0 and in_ready=1; a new sample 5 then yields 5 (delay line was cleared).
